// File: rtl/icache_refill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_responder
//  Description : Memory-side responder for the I-cache refill read channel.
//                Accepts a burst request (valid/addr/len) and streams len+1
//                32-bit beats out of a word memory, one beat per r_ready_o
//                pulse, with r_last_o flagging the final beat.  The word
//                memory is loaded through a side write port (ld_*).
//
//  Ports       : clock, reset        - clock, async active-high reset
//                r_valid_i/addr/len  - refill request (held until r_last_o)
//                r_ready_o/data/last - beat strobe, data, final-beat flag
//                r_err_o             - beat address outside backing memory
//                busy_o              - engine not idle
//                ld_we_i/idx/data    - preload write port
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LEN_WIDTH  = 8,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h3000_0000,
    parameter int                    FIRST_LAT  = 2,
    parameter int                    BEAT_GAP   = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         r_valid_i,
    input  logic [ADDR_WIDTH-1:0]        r_addr_i,
    input  logic [LEN_WIDTH-1:0]         r_len_i,
    output logic                         r_ready_o,
    output logic [DATA_WIDTH-1:0]        r_data_o,
    output logic                         r_last_o,
    output logic                         r_err_o,
    output logic                         busy_o,
    input  logic                         ld_we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_idx_i,
    input  logic [DATA_WIDTH-1:0]        ld_data_i
);

    localparam int c_idx_w = $clog2(MEM_DEPTH);
    localparam int c_cnt_w = 16;

    localparam logic [ADDR_WIDTH-1:0] c_depth    = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_word_msk = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] c_step     = ADDR_WIDTH'(4);
    // Terminal counts; the zero-parameter cases never enter LAT/GAP.
    localparam logic [c_cnt_w-1:0]    c_lat_last = c_cnt_w'((FIRST_LAT > 0) ? FIRST_LAT - 1 : 0);
    localparam logic [c_cnt_w-1:0]    c_gap_last = c_cnt_w'((BEAT_GAP  > 0) ? BEAT_GAP  - 1 : 0);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_lat  = 3'd1;
    localparam logic [2:0] c_st_beat = 3'd2;
    localparam logic [2:0] c_st_gap  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_beats_left;
    logic [c_cnt_w-1:0]    r_lat_cnt;
    logic [c_cnt_w-1:0]    r_gap_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  r_err;
    logic                  r_busy;

    logic [ADDR_WIDTH-1:0] w_word_off;
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Word offset of the current beat address from the base of memory.
    // Addresses below the base wrap to huge offsets, but are rejected by the
    // explicit lower-bound compare anyway.
    assign w_word_off = (r_addr - BASE_ADDR) >> 2;
    assign w_in_range = (r_addr >= BASE_ADDR) && (w_word_off < c_depth);
    assign w_rd_data  = w_in_range ? r_mem[w_word_off[c_idx_w-1:0]] : '0;

    // Preload port.  A write landing on the word being read at the same edge
    // does not bypass: the beat register captures the pre-write contents.
    always_ff @(posedge clock) begin
        if (ld_we_i && (32'(ld_idx_i) < MEM_DEPTH)) begin
            r_mem[ld_idx_i] <= ld_data_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_lat_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_ready      <= 1'b0;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Beat outputs are single-cycle strobes; only BEAT raises them.
            r_ready <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (r_valid_i) begin
                        r_addr       <= r_addr_i & c_word_msk;
                        r_beats_left <= r_len_i;
                        r_lat_cnt    <= '0;
                        r_gap_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= (FIRST_LAT > 0) ? c_st_lat : c_st_beat;
                    end
                end

                c_st_lat: begin
                    if (r_lat_cnt == c_lat_last) begin
                        r_state <= c_st_beat;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end

                c_st_beat: begin
                    r_ready <= 1'b1;
                    r_data  <= w_rd_data;
                    r_err   <= ~w_in_range;
                    r_addr  <= r_addr + c_step;
                    if (r_beats_left == '0) begin
                        r_last  <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_beats_left <= r_beats_left - 1'b1;
                        if (BEAT_GAP > 0) begin
                            r_gap_cnt <= '0;
                            r_state   <= c_st_gap;
                        end
                    end
                end

                c_st_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= c_st_beat;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                c_st_done: begin
                    // A valid still held from the finished burst must not
                    // launch a second one; wait for the initiator to drop it.
                    if (!r_valid_i) begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign r_ready_o = r_ready;
    assign r_data_o  = r_data;
    assign r_last_o  = r_last;
    assign r_err_o   = r_err;
    assign busy_o    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_responder
//  Description : Self-checking bench for icache_refill_responder.  Two
//                instances share all inputs: A uses FIRST_LAT=2/BEAT_GAP=0,
//                B uses FIRST_LAT=0/BEAT_GAP=1.  Expected beats come from a
//                burst-level model (address arithmetic over a memory image
//                and the beat schedule lat+1+k*(gap+1)).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_responder;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT_A = 2;
    localparam int          GAP_A = 0;
    localparam int          LAT_B = 0;
    localparam int          GAP_B = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        r_valid;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic        ld_we;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    logic        a_ready, a_last, a_err, a_busy;
    logic [31:0] a_data;
    logic        b_ready, b_last, b_err, b_busy;
    logic [31:0] b_data;

    bit [31:0]   mdl_mem [DEPTH];
    int          n_checks = 0;
    int          n_err    = 0;

    always #5 clock = ~clock;

    icache_refill_responder #(
        .FIRST_LAT (LAT_A),
        .BEAT_GAP  (GAP_A)
    ) u_dut_a (
        .clock     (clock),
        .reset     (reset),
        .r_valid_i (r_valid),
        .r_addr_i  (r_addr),
        .r_len_i   (r_len),
        .r_ready_o (a_ready),
        .r_data_o  (a_data),
        .r_last_o  (a_last),
        .r_err_o   (a_err),
        .busy_o    (a_busy),
        .ld_we_i   (ld_we),
        .ld_idx_i  (ld_idx),
        .ld_data_i (ld_data)
    );

    icache_refill_responder #(
        .FIRST_LAT (LAT_B),
        .BEAT_GAP  (GAP_B)
    ) u_dut_b (
        .clock     (clock),
        .reset     (reset),
        .r_valid_i (r_valid),
        .r_addr_i  (r_addr),
        .r_len_i   (r_len),
        .r_ready_o (b_ready),
        .r_data_o  (b_data),
        .r_last_o  (b_last),
        .r_err_o   (b_err),
        .busy_o    (b_busy),
        .ld_we_i   (ld_we),
        .ld_idx_i  (ld_idx),
        .ld_data_i (ld_data)
    );

    // Expected {ready,last,err,busy,data} c edges after the accepting edge,
    // when valid is dropped just before edge d.
    function automatic logic [35:0] exp_out(int lat, int gap, int c, int d,
                                            logic [31:0] addr, int len);
        logic        rdy, lst, er, bsy;
        logic [31:0] dat, a, off;
        int          k;
        rdy = 1'b0; lst = 1'b0; er = 1'b0; dat = '0;
        bsy = (c < d);
        if (c >= lat + 1 && ((c - lat - 1) % (gap + 1)) == 0) begin
            k = (c - lat - 1) / (gap + 1);
            if (k <= len) begin
                rdy = 1'b1;
                lst = (k == len);
                a   = (addr & 32'hFFFF_FFFC) + 32'(4 * k);
                off = (a - BASE) >> 2;
                if (a >= BASE && off < 32'(DEPTH)) dat = mdl_mem[off];
                else er = 1'b1;
            end
        end
        return {rdy, lst, er, bsy, dat};
    endfunction

    task automatic test_reset();
        reset = 1'b1; r_valid = 1'b0; r_addr = '0; r_len = '0;
        ld_we = 1'b0; ld_idx = '0; ld_data = '0;
        repeat (2) @(negedge clock);
        n_checks++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_ready got %b want 0", a_ready); end
        n_checks++; if (a_data !== 32'h0) begin n_err++; $display("FAIL reset_a_data got %h want 0", a_data); end
        n_checks++; if (a_last !== 1'b0) begin n_err++; $display("FAIL reset_a_last got %b want 0", a_last); end
        n_checks++; if (a_err !== 1'b0) begin n_err++; $display("FAIL reset_a_err got %b want 0", a_err); end
        n_checks++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_a_busy got %b want 0", a_busy); end
        n_checks++; if ({b_ready, b_last, b_err, b_busy, b_data} !== 36'h0) begin
            n_err++; $display("FAIL reset_b got %h want 0", {b_ready, b_last, b_err, b_busy, b_data});
        end
        reset = 1'b0;
    endtask

    task automatic preload_all();
        @(negedge clock);
        ld_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ld_idx  = 10'(i);
            ld_data = $urandom;
            mdl_mem[i] = ld_data;
            @(negedge clock);
        end
        ld_we = 1'b0;
    endtask

    task automatic preload_word(input int idx, input logic [31:0] val);
        @(negedge clock);
        ld_we = 1'b1; ld_idx = 10'(idx); ld_data = val;
        mdl_mem[idx] = val;
        @(negedge clock);
        ld_we = 1'b0;
    endtask

    // One burst checked cycle by cycle on both instances.  With collide set,
    // word of beat 2 is rewritten at the very edge both instances read it.
    task automatic run_burst(input logic [31:0] addr, input int len,
                             input int hold, input bit collide, input string name);
        int          last_a, last_b, d, cidx;
        logic [35:0] exp, act;
        logic [31:0] cdata, a2;
        last_a = LAT_A + 1 + len * (GAP_A + 1);
        last_b = LAT_B + 1 + len * (GAP_B + 1);
        d      = ((last_a > last_b) ? last_a : last_b) + 1 + hold;
        a2     = (addr & 32'hFFFF_FFFC) + 32'd8;
        cidx   = int'((a2 - BASE) >> 2);
        cdata  = $urandom;
        @(negedge clock);
        r_valid = 1'b1; r_addr = addr; r_len = 8'(len);
        @(posedge clock);
        for (int c = 0; c <= d + 2; c++) begin
            @(negedge clock);
            exp = exp_out(LAT_A, GAP_A, c, d, addr, len);
            act = {a_ready, a_last, a_err, a_busy, a_data};
            n_checks++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s dutA cyc %0d got %h want %h", name, c, act, exp);
            end
            exp = exp_out(LAT_B, GAP_B, c, d, addr, len);
            act = {b_ready, b_last, b_err, b_busy, b_data};
            n_checks++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s dutB cyc %0d got %h want %h", name, c, act, exp);
            end
            // Request fields must be ignored after acceptance.
            r_addr = $urandom;
            r_len  = 8'($urandom);
            if (c == d - 1) r_valid = 1'b0;
            if (collide && c == 4) begin
                ld_we = 1'b1; ld_idx = 10'(cidx); ld_data = cdata;
            end
            if (collide && c == 5) ld_we = 1'b0;
        end
        if (collide) mdl_mem[cidx] = cdata;
    endtask

    task automatic test_reset_midburst();
        logic [35:0] act;
        @(negedge clock);
        r_valid = 1'b1; r_addr = BASE + 32'd40; r_len = 8'd7;
        @(posedge clock);
        repeat (4) @(posedge clock);
        #2;
        n_checks++;
        if ({a_ready, a_data} !== {1'b1, mdl_mem[11]}) begin
            n_err++; $display("FAIL midburst_beat1 got %h want %h", {a_ready, a_data}, {1'b1, mdl_mem[11]});
        end
        reset = 1'b1;
        #1;
        act = {a_ready, a_last, a_err, a_busy, a_data};
        n_checks++; if (act !== 36'h0) begin n_err++; $display("FAIL midburst_reset_a got %h want 0", act); end
        act = {b_ready, b_last, b_err, b_busy, b_data};
        n_checks++; if (act !== 36'h0) begin n_err++; $display("FAIL midburst_reset_b got %h want 0", act); end
        @(negedge clock);
        r_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            act = {a_ready, a_last, a_err, a_busy, a_data, b_ready, b_last, b_err, b_busy};
            n_checks++;
            if (act !== '0) begin n_err++; $display("FAIL post_reset_quiet cyc %0d got %h want 0", c, act); end
        end
        run_burst(BASE + 32'd100, 5, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          len, hold, w;
        bit          col;
        for (int i = 0; i < 10; i++) begin
            w    = $urandom_range(0, 1100);
            addr = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
            len  = $urandom_range(0, 12);
            hold = $urandom_range(0, 2);
            col  = (len >= 2) && (w + 2 < DEPTH) && ($urandom_range(0, 1) == 1);
            run_burst(addr, len, hold, col, "random");
        end
    endtask

    initial begin
        test_reset();
        preload_all();
        // Basic 4-beat burst over known contents
        preload_word(0, 32'd1);
        preload_word(1, 32'd2);
        preload_word(2, 32'd3);
        preload_word(3, 32'd4);
        run_burst(BASE, 3, 0, 1'b0, "basic4");
        // Misaligned single-beat request
        run_burst(BASE + 32'd7, 0, 0, 1'b0, "single");
        // Last word then one past the end
        run_burst(BASE + 32'(4 * (DEPTH - 1)), 1, 0, 1'b0, "top_edge");
        // Stale valid held past the final beat
        run_burst(BASE + 32'd64, 2, 3, 1'b0, "stale_valid");
        // Address straddling the base from below
        run_burst(BASE - 32'd8, 3, 0, 1'b0, "below_base");
        // 32-bit address wrap
        run_burst(32'hFFFF_FFF8, 3, 1, 1'b0, "wrap");
        // Same-edge preload write of the word being read
        run_burst(BASE + 32'd16, 4, 0, 1'b1, "collide");
        // Maximum length crossing the top of memory
        run_burst(BASE + 32'(4 * 900), 255, 0, 1'b0, "max_len");
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
